// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and word geometry for the instruction-memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERROR} state_t;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: big-endian byte-to-word shift register with byte index and XOR checksum
module imem_loader_byte_packer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] next_word,
  output logic [1:0]  idx,
  output logic [7:0]  cksum
);
  logic [23:0] acc;
  always_comb next_word = {acc, din};
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      acc   <= '0;
      idx   <= '0;
      cksum <= '0;
    end else if (en) begin
      acc   <= next_word[23:0];
      idx   <= idx + 2'd1;
      cksum <= cksum ^ din;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a checksummed big-endian program into instruction memory while holding the CPU in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int EW = ADDR_W + 18;
  state_t state, next;
  logic [ADDR_W-1:0] base;
  logic [15:0] count, word_idx;
  logic [31:0] next_word;
  logic [1:0] idx;
  logic [7:0] cksum;
  logic [EW-1:0] end_addr;
  logic can_start, xfer, last_byte, ok;
  always_comb begin
    can_start = state inside {IDLE, DONE, ERROR};
    xfer      = in_valid && in_ready;
    last_byte = state == LOAD && xfer && idx == 2'd3;
    end_addr  = EW'(base_addr) + EW'(word_count) * EW'(WORD_BYTES);
    ok        = word_count != 16'd0 && word_count <= 16'(MAX_WORDS) &&
                base_addr[1:0] == 2'b00 && end_addr <= (EW'(1) << ADDR_W);
  end
  imem_loader_byte_packer u_packer (
    .CLK      (CLK),
    .RESET    (RESET),
    .clr      (start && can_start),
    .en       (state == LOAD && xfer),
    .din      (in_data),
    .next_word(next_word),
    .idx      (idx),
    .cksum    (cksum)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      base      <= '0;
      count     <= '0;
      word_idx  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= next;
      if (start && can_start && ok) begin
        base     <= base_addr;
        count    <= word_count;
        word_idx <= '0;
      end
      if (last_byte) begin
        mem_addr  <= base + ADDR_W'(word_idx * WORD_BYTES);
        mem_wdata <= next_word;
      end
      if (state == WRITE) word_idx <= word_idx + 16'd1;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, ERROR: if (start) next = ok ? LOAD : ERROR;
      LOAD:              if (last_byte) next = WRITE;
      WRITE:             next = word_idx + 16'd1 == count ? CHECK : LOAD;
      CHECK:             if (xfer) next = in_data == cksum ? DONE : ERROR;
      default:           next = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == LOAD || state == CHECK;
    mem_we   = state == WRITE;
    busy     = state inside {LOAD, WRITE, CHECK};
    done     = state == DONE;
    error    = state == ERROR;
    cpu_hold = state != DONE;
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a byte-stream reference model
module tb_imem_loader;
  logic CLK = 0, RESET = 1, start = 0, in_valid = 0;
  logic [9:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [7:0] in_data = '0;
  logic in_ready, mem_we, cpu_hold, busy, done, error;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata;
  int checks = 0, errors = 0;
  logic [7:0] stim[$];
  logic [9:0] wa[$], ea[$];
  logic [31:0] wd[$], ed[$];
  bit prev_we = 0, double_we = 0;
  imem_loader dut (
    .CLK(CLK), .RESET(RESET), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (mem_we && prev_we) double_we = 1;
    prev_we = mem_we;
  end
  function automatic void clear_obs();
    wa.delete(); wd.delete(); double_we = 0;
  endfunction
  function automatic void rand_stim(input int n);
    stim.delete();
    repeat (n) stim.push_back(8'($urandom));
  endfunction
  function automatic logic [7:0] xsum();
    logic [7:0] x;
    x = '0;
    foreach (stim[i]) x ^= stim[i];
    return x;
  endfunction
  function automatic void model(input logic [9:0] b);
    ea.delete(); ed.delete();
    for (int i = 3; i < stim.size(); i += 4) begin
      ea.push_back(b + 10'(i - 3));
      ed.push_back({stim[i-3], stim[i-2], stim[i-1], stim[i]});
    end
  endfunction
  task automatic pulse_start(input logic [9:0] b, input logic [15:0] c);
    start = 1; base_addr = b; word_count = c;
    @(negedge CLK);
    start = 0;
  endtask
  task automatic send_byte(input logic [7:0] v);
    int n = 0;
    in_valid = 1; in_data = v;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b want=1", in_ready);
    end
    @(negedge CLK);
    in_valid = 0;
  endtask
  task automatic send_all(input logic [7:0] ck, input int gap);
    foreach (stim[i]) begin
      if ((gap == 2 && i > 0) || (gap == 1 && $urandom_range(0, 2) == 0)) @(negedge CLK);
      send_byte(stim[i]);
    end
    send_byte(ck);
  endtask
  task automatic cmp_writes(input string name);
    checks++;
    if (wa.size() != ea.size()) begin
      errors++;
      $display("FAIL %s_nwrites got=%0d want=%0d", name, wa.size(), ea.size());
    end
    foreach (ea[i]) if (i < wa.size()) begin
      checks++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        errors++;
        $display("FAIL %s_write%0d got=%h@%h want=%h@%h", name, i, wd[i], wa[i], ed[i], ea[i]);
      end
    end
    checks++;
    if (double_we) begin
      errors++;
      $display("FAIL %s_we_pulse got=multi-cycle want=single-cycle", name);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold} !== {45'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b %h %h %b%b%b%b want=00 000 00000000 0001",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold);
    end
    RESET = 0;
    @(negedge CLK);
  endtask
  task automatic test_basic(input logic [7:0] ck, input bit good, input string name);
    stim = '{8'h00, 8'h00, 8'h10, 8'h20, 8'h00, 8'h64, 8'h28, 8'h24};
    clear_obs();
    model(10'd0);
    pulse_start(10'd0, 16'd2);
    send_all(ck, 0);
    checks++;
    if ({done, error, cpu_hold} !== {good, !good, !good}) begin
      errors++;
      $display("FAIL %s_status got=%b%b%b want=%b%b%b", name, done, error, cpu_hold, good, !good, !good);
    end
    cmp_writes(name);
  endtask
  task automatic test_invalid();
    logic [9:0] bs[5] = '{10'd0, 10'd2, 10'd1020, 10'd0, 10'd4};
    logic [15:0] cs[5] = '{16'd0, 16'd1, 16'd2, 16'd257, 16'd256};
    for (int k = 0; k < 5; k++) begin
      clear_obs();
      pulse_start(bs[k], cs[k]);
      in_valid = 1; in_data = 8'hAA;
      for (int j = 0; j < 3; j++) begin
        checks++;
        if ({error, in_ready, busy, done} !== 4'b1000) begin
          errors++;
          $display("FAIL invalid%0d_c%0d got=%b%b%b%b want=1000", k, j, error, in_ready, busy, done);
        end
        @(negedge CLK);
      end
      in_valid = 0;
      checks++;
      if (wa.size() != 0) begin
        errors++;
        $display("FAIL invalid%0d_writes got=%0d want=0", k, wa.size());
      end
    end
  endtask
  task automatic test_stall();
    logic [7:0] ck;
    rand_stim(4); ck = xsum(); model(10'd12); clear_obs();
    pulse_start(10'd12, 16'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      if (i == 3) begin
        checks++;
        if (wa.size() != 0 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL stall_early_we got=%0d/%b want=0/0", wa.size(), mem_we);
        end
      end
      send_byte(stim[i]);
    end
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL stall_latency mem_we=%b want=1", mem_we);
    end
    @(negedge CLK);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL stall_we_width mem_we=%b want=0", mem_we);
    end
    send_byte(ck);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got=%b want=1", done);
    end
    cmp_writes("stall");
  endtask
  task automatic test_reset_mid();
    logic [7:0] ck;
    rand_stim(8); model(10'h100); ea.pop_back(); ed.pop_back(); clear_obs();
    pulse_start(10'h100, 16'd2);
    for (int i = 0; i < 6; i++) send_byte(stim[i]);
    RESET = 1;
    @(negedge CLK);
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold} !== {45'd0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_outputs got=%b%b %h %h %b%b%b%b want=00 000 00000000 0001",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold);
    end
    RESET = 0;
    cmp_writes("rstmid");
    rand_stim(8); ck = xsum(); model(10'h40); clear_obs();
    @(negedge CLK);
    pulse_start(10'h40, 16'd2);
    send_all(ck, 1);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reload_done got=%b want=1", done);
    end
    cmp_writes("rstmid_reload");
  endtask
  task automatic test_restart();
    logic [7:0] ck;
    rand_stim(8); ck = xsum(); model(10'd0); clear_obs();
    pulse_start(10'd0, 16'd2);
    send_byte(stim[0]); send_byte(stim[1]);
    pulse_start(10'd4, 16'd0);
    checks++;
    if ({busy, error} !== 2'b10) begin
      errors++;
      $display("FAIL restart_ignored got=busy%b err%b want=busy1 err0", busy, error);
    end
    for (int i = 2; i < 8; i++) send_byte(stim[i]);
    send_byte(ck);
    checks++;
    if ({done, cpu_hold} !== 2'b10) begin
      errors++;
      $display("FAIL restart_first got=%b%b want=10", done, cpu_hold);
    end
    cmp_writes("restart_first");
    rand_stim(4); ck = xsum(); model(10'd8); clear_obs();
    pulse_start(10'd8, 16'd1);
    checks++;
    if ({cpu_hold, done, busy} !== 3'b101) begin
      errors++;
      $display("FAIL restart_hold got=%b%b%b want=101", cpu_hold, done, busy);
    end
    send_all(ck, 0);
    checks++;
    if ({done, cpu_hold} !== 2'b10) begin
      errors++;
      $display("FAIL restart_second got=%b%b want=10", done, cpu_hold);
    end
    cmp_writes("restart_second");
  endtask
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int c;
      logic [9:0] b;
      logic [7:0] ck;
      bit good;
      c = it == 0 ? 2 : int'($urandom_range(1, 6));
      b = it == 0 ? 10'd1016 : 10'(4 * $urandom_range(0, 256 - c));
      rand_stim(4 * c);
      good = it == 0 || $urandom_range(0, 2) != 0;
      ck = good ? xsum() : xsum() ^ 8'(1 + $urandom_range(0, 254));
      model(b); clear_obs();
      pulse_start(b, 16'(c));
      send_all(ck, 1);
      checks++;
      if ({done, error, cpu_hold} !== {good, !good, !good}) begin
        errors++;
        $display("FAIL random%0d_status got=%b%b%b want=%b%b%b", it, done, error, cpu_hold, good, !good, !good);
      end
      cmp_writes($sformatf("random%0d", it));
    end
  endtask
  initial begin
    test_reset();
    test_basic(8'h58, 1'b1, "basic");
    test_basic(8'h00, 1'b0, "badck");
    test_invalid();
    test_stall();
    test_reset_mid();
    test_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
